// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output path.
//   DW / LANES / FRAME : sample width, samples per parallel word, samples per frame
//   sample_t, pword_t  : one complex sample and one 4-lane parallel word
//   wcnt_t, rcnt_t     : write-side word counter and read-side sample counter
//   rd_state_t         : read-side FSM states
//   bitrev4            : 4-bit index reversal used by the optional bit-reversed readout
package fft_pkg;

    localparam int DW     = 34;
    localparam int LANES  = 4;
    localparam int FRAME  = LANES * LANES;
    localparam int WCNT_W = 2;
    localparam int RCNT_W = 4;

    typedef logic [DW-1:0]       sample_t;
    typedef logic [LANES*DW-1:0] pword_t;
    typedef logic                bank_t;
    typedef logic [WCNT_W-1:0]   wcnt_t;
    typedef logic [RCNT_W-1:0]   rcnt_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_t;

    function automatic rcnt_t bitrev4(input rcnt_t idx);
        return {idx[0], idx[1], idx[2], idx[3]};
    endfunction

endpackage

// File: rtl/p_s_bank.sv
// One frame buffer: 16 samples of DW bits.
//   clk     : rising-edge clock
//   wr_en   : write one parallel word into column col
//   col     : word number within the frame (0..3)
//   wr_data : 4-lane word; lane j lands in sample 4*j + col
//   rd_idx  : sample index to read (0..15)
//   rd_data : combinational read of sample rd_idx
// Storage is intentionally not reset.
import fft_pkg::*;

module p_s_bank (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [WCNT_W-1:0] col,
    input  logic [LANES*DW-1:0] wr_data,
    input  logic [RCNT_W-1:0] rd_idx,
    output logic [DW-1:0]     rd_data
);

    sample_t mem [FRAME];

    // Sample index 4*j + col is simply the concatenation {j, col}.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < LANES; j++) begin
                mem[{j[1:0], col}] <= wr_data[j*DW +: DW];
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/p_s.sv
// Parallel-to-serial converter at the FFT output.
// Takes 4-lane words (four per 16-sample frame), un-transposes them into a
// ping-pong pair of frame buffers and streams one sample per clock.
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   data_in_1    : parallel word, lane j = bits [34j+33:34j]
//   p_s_flag_in  : word valid
//   p_s_ready    : word accepted when p_s_flag_in && p_s_ready
//   data_out_1   : serial sample
//   p_s_flag_out : data_out_1 valid
//   p_s_sof      : first sample of a frame
//   p_s_ovf      : sticky, a word was offered while p_s_ready was low
// Build option: define P_S_BITREV_EN to read each frame in bit-reversed order.
import fft_pkg::*;

module p_s (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LANES*DW-1:0] data_in_1,
    input  logic                p_s_flag_in,
    output logic                p_s_ready,
    output logic [DW-1:0]       data_out_1,
    output logic                p_s_flag_out,
    output logic                p_s_sof,
    output logic                p_s_ovf
);

    bank_t     wr_bank;
    wcnt_t     wr_cnt;
    bank_t     rd_bank;
    bank_t     rd_bank_nxt;
    rcnt_t     rd_cnt;
    rcnt_t     rd_cnt_nxt;
    rcnt_t     rd_idx;
    logic [1:0] bank_full;
    logic [1:0] bank_full_nxt;
    rd_state_t state;
    rd_state_t state_nxt;
    logic      accept;
    logic      last_word;
    logic      emit;
    logic      release_bank;
    sample_t   rd_data0;
    sample_t   rd_data1;
    sample_t   rd_sample;

    // Ready depends on registered state only.
    assign p_s_ready = !bank_full[wr_bank];
    assign accept    = p_s_flag_in && p_s_ready;
    assign last_word = (wr_cnt == WCNT_W'(LANES-1));

`ifdef P_S_BITREV_EN
    assign rd_idx = bitrev4(rd_cnt);
`else
    assign rd_idx = rd_cnt;
`endif

    p_s_bank u_bank0 (
        .clk     (clk),
        .wr_en   (accept && (wr_bank == 1'b0)),
        .col     (wr_cnt),
        .wr_data (data_in_1),
        .rd_idx  (rd_idx),
        .rd_data (rd_data0)
    );

    p_s_bank u_bank1 (
        .clk     (clk),
        .wr_en   (accept && (wr_bank == 1'b1)),
        .col     (wr_cnt),
        .wr_data (data_in_1),
        .rd_idx  (rd_idx),
        .rd_data (rd_data1)
    );

    assign rd_sample = rd_bank ? rd_data1 : rd_data0;

    // Read FSM. IDLE emits sample 0 in the same cycle it sees a full bank so
    // the first sample appears one edge after the frame completes.
    always_comb begin
        state_nxt    = state;
        rd_cnt_nxt   = rd_cnt;
        rd_bank_nxt  = rd_bank;
        emit         = 1'b0;
        release_bank = 1'b0;
        case (state)
            IDLE:    emit = bank_full[rd_bank];
            STREAM:  emit = 1'b1;
            default: emit = 1'b0;
        endcase
        if (emit) begin
            rd_cnt_nxt = rd_cnt + 1'b1;
            state_nxt  = STREAM;
            if (rd_cnt == RCNT_W'(FRAME-1)) begin
                release_bank = 1'b1;
                rd_bank_nxt  = !rd_bank;
                // A frame completing on this same edge is picked up from IDLE
                // next cycle, which still leaves no gap.
                if (!bank_full[!rd_bank]) begin
                    state_nxt = IDLE;
                end
            end
        end
    end

    // Release and fill always target different banks, so both apply.
    always_comb begin
        bank_full_nxt = bank_full;
        if (release_bank) begin
            bank_full_nxt[rd_bank] = 1'b0;
        end
        if (accept && last_word) begin
            bank_full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_bank   <= 1'b0;
            rd_cnt    <= '0;
            bank_full <= '0;
            p_s_ovf   <= 1'b0;
        end else begin
            rd_bank   <= rd_bank_nxt;
            rd_cnt    <= rd_cnt_nxt;
            bank_full <= bank_full_nxt;
            if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (last_word) begin
                    wr_bank <= !wr_bank;
                end
            end
            if (p_s_flag_in && !p_s_ready) begin
                p_s_ovf <= 1'b1;
            end
        end
    end

    // Output register: data holds its last value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_1   <= '0;
            p_s_flag_out <= 1'b0;
            p_s_sof      <= 1'b0;
        end else begin
            p_s_flag_out <= emit;
            p_s_sof      <= emit && (rd_cnt == '0);
            if (emit) begin
                data_out_1 <= rd_sample;
            end
        end
    end

endmodule

// File: tb/tb_p_s.sv
module tb_p_s;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [135:0] data_in_1 = '0;
    logic         p_s_flag_in = 1'b0;
    logic         p_s_ready;
    logic [33:0]  data_out_1;
    logic         p_s_flag_out;
    logic         p_s_sof;
    logic         p_s_ovf;

    always #5 clk = ~clk;

    p_s dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in_1    (data_in_1),
        .p_s_flag_in  (p_s_flag_in),
        .p_s_ready    (p_s_ready),
        .data_out_1   (data_out_1),
        .p_s_flag_out (p_s_flag_out),
        .p_s_sof      (p_s_sof),
        .p_s_ovf      (p_s_ovf)
    );

    typedef struct {
        logic [33:0] data;
        bit          sof;
        bit          last;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          completed = 0;
    int          drained = 0;
    int          wcount = 0;
    int          prev_start = -1000;
    bit          exp_ovf = 1'b0;
    logic [33:0] wbuf [4][4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, req);
        end
    endtask

    // Position in the frame of the sample emitted at output slot c.
    function automatic int rd_order(input int c);
`ifdef P_S_BITREV_EN
        return ((c & 1) << 3) | ((c & 2) << 1) | ((c & 4) >> 1) | ((c & 8) >> 3);
`else
        return c;
`endif
    endfunction

    function automatic logic [33:0] rand_sample();
        return {2'($urandom_range(3, 0)), 32'($urandom)};
    endfunction

    // A frame finished at edge n_edge: rebuild it from the stored words and
    // queue its 16 outputs with the cycle each must appear on.
    task automatic frame_done(input int n_edge);
        logic [33:0] fr [16];
        exp_t e;
        int   start;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++)
                fr[4*j + k] = wbuf[k][j];
        start = (n_edge + 1 > prev_start + 16) ? n_edge + 1 : prev_start + 16;
        for (int i = 0; i < 16; i++) begin
            e.data = fr[rd_order(i)];
            e.sof  = (i == 0);
            e.last = (i == 15);
            e.cyc  = start + i;
            q.push_back(e);
        end
        prev_start = start;
        completed++;
    endtask

    // One input cycle. The model says a word fits unless two frames are
    // buffered and not yet fully emitted.
    task automatic drive(input logic [135:0] w, input bit v);
        bit pred;
        @(negedge clk);
        #1;
        data_in_1   = w;
        p_s_flag_in = v;
        if (v) begin
            pred = ((completed - drained) < 2);
            check("ready", 64'(p_s_ready), 64'(pred));
            if (pred) begin
                for (int j = 0; j < 4; j++) wbuf[wcount][j] = w[34*j +: 34];
                wcount++;
                if (wcount == 4) begin
                    wcount = 0;
                    frame_done(cyc + 1);
                end
            end else begin
                exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic feed_frame(input int base, input int gap, input bit rnd);
        logic [33:0]  fr [16];
        logic [135:0] w;
        for (int i = 0; i < 16; i++) fr[i] = rnd ? rand_sample() : 34'(base + i);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) w[34*j +: 34] = fr[4*j + k];
            drive(w, 1'b1);
            if (k < 3) repeat (gap) drive('0, 1'b0);
        end
        drive('0, 1'b0);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 400) begin
            drive('0, 1'b0);
            t++;
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d samples still pending, required 0", q.size());
            q.delete();
        end
        repeat (3) drive('0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  64'(data_out_1),   64'(0));
        check({tag, "_flag"},  64'(p_s_flag_out), 64'(0));
        check({tag, "_sof"},   64'(p_s_sof),      64'(0));
        check({tag, "_ovf"},   64'(p_s_ovf),      64'(0));
        check({tag, "_ready"}, 64'(p_s_ready),    64'(1));
    endtask

    // Monitor: every presented sample is matched against the queue head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (p_s_flag_out) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_out at cycle %0d: got sample %0h, required no output", cyc, data_out_1);
                end else begin
                    e = q.pop_front();
                    check("data", 64'(data_out_1), 64'(e.data));
                    check("sof",  64'(p_s_sof),    64'(e.sof));
                    check("time", 64'(cyc),        64'(e.cyc));
                    if (e.last) drained++;
                end
            end else begin
                if (p_s_sof) check("sof_idle", 64'(p_s_sof), 64'(0));
                if (q.size() != 0 && q[0].cyc <= cyc) begin
                    e = q.pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL missing_out at cycle %0d: got no output, required sample %0h", cyc, e.data);
                    if (e.last) drained++;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [135:0] w;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;
        repeat (2) drive('0, 1'b0);

        // Single frame, sample value = index.
        feed_frame(0, 0, 1'b0);
        wait_drain();

        // Three frames, one every 16 cycles, must stream without gaps.
        for (int f = 0; f < 3; f++) begin
            feed_frame(16 * f, 0, 1'b0);
            repeat (11) drive('0, 1'b0);
        end
        wait_drain();
        check("ovf_clear", 64'(p_s_ovf), 64'(0));

        // Nine consecutive words: the ninth is refused and dropped.
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 4; j++) w[34*j +: 34] = 34'(16*f + 4*j + k);
                drive(w, 1'b1);
            end
        end
        drive({4{34'h3ffff}}, 1'b1);
        drive('0, 1'b0);
        check("ovf_set", 64'(p_s_ovf), 64'(exp_ovf));
        wait_drain();

        // Words spaced by three idle cycles.
        feed_frame(200, 3, 1'b0);
        wait_drain();

        // Random data with random gaps, including backpressure periods.
        for (int n = 0; n < 120; n++) begin
            for (int j = 0; j < 4; j++) w[34*j +: 34] = rand_sample();
            drive(w, 1'b1);
            repeat ($urandom_range(4, 0)) drive('0, 1'b0);
        end
        wait_drain();

        // Reset while sample 7 of a frame is on the output.
        feed_frame(300, 0, 1'b0);
        while (cyc < prev_start + 7) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        q.delete();
        completed  = 0;
        drained    = 0;
        wcount     = 0;
        prev_start = -1000;
        exp_ovf    = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) drive('0, 1'b0);
        feed_frame(0, 1, 1'b1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/p_s.md
Name: p_s

Overview:
- Parallel-to-serial converter that sits at the FFT output. It is the inverse of the input serial-to-parallel stage.
- Accepts 4-lane parallel words (4 x 34-bit complex samples, 136 bits) from the butterfly datapath and un-transposes each 16-sample frame.
- Emits the frame as one 34-bit sample per clock.
- Ping-pong buffered, so back-to-back frames stream with no gap on the serial side.

Parameters:
- DW, 34, sample width (17-bit real + 17-bit imaginary).
- LANES, 4, samples per parallel word.
- FRAME, 16, samples per frame (LANES*LANES); fixed, not independently settable.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in_1  input  136  parallel word; lane j = bits [34j+33:34j].
- p_s_flag_in  input  1  word valid.
- p_s_ready  output  1  word accepted when p_s_flag_in && p_s_ready.
- data_out_1  output  34  serial sample.
- p_s_flag_out  output  1  data_out_1 valid.
- p_s_sof  output  1  high with the first sample of each frame.
- p_s_ovf  output  1  sticky: a word was offered while p_s_ready was low.

Behaviour:
- Reset: the single clock is clk. Reset rst_n is asynchronous and active-low.
  - Reset clears all control state: wr_bank, wr_cnt, rd_bank, rd_cnt, bank_full[1:0], state=IDLE.
  - Reset values: data_out_1=0, p_s_flag_out=0, p_s_sof=0, p_s_ovf=0, p_s_ready=1.
  - Bank data registers are not reset.
- Input mapping: accepted word k (wr_cnt=k, 0..3) lane j is stored as frame sample 4j+k.
  - Word 0 = {S12,S8,S4,S0}, word 1 = {S13,S9,S5,S1}, and so on.
- Write side:
  - Accepted words fill bank[wr_bank]; wr_cnt increments on each acceptance.
  - On the 4th word: set bank_full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
  - p_s_ready = !bank_full[wr_bank], decoded from registers only. There is no combinational path from p_s_flag_in.
  - Words need not be consecutive; gaps are allowed mid-frame.
- Overflow: p_s_flag_in=1 with p_s_ready=0 drops the word and sets p_s_ovf. p_s_ovf clears only on reset.
- Read FSM, two states:
  - IDLE: if bank_full[rd_bank], go to STREAM with rd_cnt=0.
  - STREAM: each cycle register data_out_1=bank[rd_bank][rd_cnt], p_s_flag_out=1, p_s_sof=(rd_cnt==0). Then rd_cnt++.
  - At rd_cnt=15: clear bank_full[rd_bank] and toggle rd_bank.
  - After rd_cnt=15, if the other bank is already full, stay in STREAM with rd_cnt=0. There is no bubble: sample 0 of the next frame follows sample 15 directly.
  - Otherwise go to IDLE; p_s_flag_out=0 and data_out_1 holds its last value.
- Latency: the 4th word accepted at edge N gives S0 registered on output at edge N+1; S15 appears at edge N+16.
- Throughput:
  - Sustains 4 words per 16 cycles indefinitely.
  - A burst of 8 consecutive words is absorbed (both banks).
  - A 9th word is refused until the first frame drains.
- Simultaneous events:
  - The read-side release of bank b and the write-side fill of bank !b in the same cycle both take effect.
  - If the writer targets the bank being released, p_s_ready rises the following cycle; no same-cycle bypass.
- Mid-operation reset: the partially written frame and any pending frames are discarded. Outputs return to reset values asynchronously.

Optional Feature:
- Macro P_S_BITREV_EN.
- Defined: the read index is bitrev4(rd_cnt), giving output order S0,S8,S4,S12,S2,S10,S6,S14,S1,S9,S5,S13,S3,S11,S7,S15. This is used when the FFT core delivers natural-order data and bit-reversed serial order is wanted, or the reverse.
- Undefined: natural order S0..S15.
- Timing, flags and p_s_sof position are identical in both cases.

Decomposition:
- Shared package fft_pkg holds:
  - constants DW=34, LANES=4, FRAME=16;
  - sample_t (34-bit), pword_t (136-bit), bank index and counter widths;
  - function bitrev4.
- One natural sub-module: p_s_bank, a 16 x 34 register array with a 4-lane column write (wr_en, col) and a 16:1 sample read mux.
- p_s instantiates two p_s_bank plus the control FSM.

Test Plan:
- Single frame: after reset, feed words {12,8,4,0},{13,9,5,1},{14,10,6,2},{15,11,7,3} (each sample value = its index) on 4 consecutive cycles. Expect data_out_1 = 0..15 on the 16 cycles starting 1 cycle after word 4, p_s_sof only with 0, p_s_flag_out low afterwards.
- Back-to-back: 3 frames (values 0..15, 16..31, 32..47) each fed as 4 words every 16 cycles. Expect 48 contiguous valid samples 0..47, with p_s_sof at 0, 16 and 32.
- Burst/backpressure: 9 consecutive words offered. Expect p_s_ready low from the 9th offer, the 9th word dropped, p_s_ovf=1; the first 32 output samples are correct.
- Gapped input: words spaced by 3 idle cycles. Expect output to start 1 cycle after word 4, with correct order.
- Reset mid-stream: assert rst_n=0 at output sample 7. Expect outputs 0 immediately and p_s_ready=1. A fresh frame after release streams correctly from S0.
- P_S_BITREV_EN build: frame values 0..15. Expect output sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
